// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register offsets, bus modes and VECTOR register layout.
package irq_pkg;

   localparam int NUM_IRQ_LINES = 8;
   localparam int IRQ_ID_W      = $clog2(NUM_IRQ_LINES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_IN_SERVICE
   } irq_state_e;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_READ  = 2'b01,
      MODE_WRITE = 2'b10,
      MODE_RSVD  = 2'b11
   } bus_mode_e;

   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_MASK    = 3'd1;
   localparam logic [2:0] OFF_PENDING = 3'd2;
   localparam logic [2:0] OFF_VECTOR  = 3'd3;
   localparam logic [2:0] OFF_EOI     = 3'd4;
   localparam int         NUM_REGS    = 5;

   localparam int VEC_VALID_BIT  = 31;
   localparam int VEC_INSERV_BIT = 30;

   function automatic logic [31:0] vector_word(input logic valid, input logic in_serv,
                                               input logic [IRQ_ID_W-1:0] id);
      logic [31:0] w;
      w                 = '0;
      w[VEC_VALID_BIT]  = valid;
      w[VEC_INSERV_BIT] = in_serv;
      w[IRQ_ID_W-1:0]   = id;
      return w;
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational fixed-priority encoder: lowest set index wins.
module irq_priority_encoder
   import irq_pkg::*;
#(
   parameter int n = NUM_IRQ_LINES,
   localparam int id_w = $clog2(n)
) (
   input  logic [n-1:0]    req,
   output logic [id_w-1:0] id,
   output logic            valid
);

   always_comb begin
      id    = '0;
      valid = |req;
      // Scan high to low so the last hit, the lowest index, is kept.
      for (int i = n - 1; i >= 0; i--) begin
         if (req[i]) id = id_w'(i);
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-detected pending bits, per-line
// mask, fixed priority and a VECTOR-read / EOI acknowledge handshake.
module irq_controller
   import irq_pkg::*;
#(
   parameter logic [31:0] base_address = 32'h40B0,
   parameter int          num_lines    = NUM_IRQ_LINES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [num_lines-1:0] irq_lines,
   inout  wire  [31:0]          data_bus_data,
   input  logic [31:0]          data_bus_addr,
   input  logic [1:0]           data_bus_mode,
   output logic                 cpu_irq,
   output logic [IRQ_ID_W-1:0]  cpu_irq_id
);

   logic [31:0]          ctrl;
   logic [num_lines-1:0] mask, pending, prev;
   logic [IRQ_ID_W-1:0]  in_service_id;
   irq_state_e           state, state_next;

   logic [31:0]          offset, rdata;
   logic [2:0]           reg_sel;
   logic                 mapped, rd, wr;
   logic                 rd_vector, wr_ctrl, wr_mask, wr_pending, wr_eoi;
   logic [num_lines-1:0] candidate, fall, ack_clr, w1c_clr;
   logic [IRQ_ID_W-1:0]  cand_id;
   logic                 cand_valid, irq_on, ack;

   // Addresses below the base wrap to large offsets and fall out of range.
   assign offset  = data_bus_addr - base_address;
   assign mapped  = offset < 32'(NUM_REGS);
   assign reg_sel = offset[2:0];
   assign rd      = mapped && (data_bus_mode == MODE_READ);
   assign wr      = mapped && (data_bus_mode == MODE_WRITE);

   assign rd_vector  = rd && (reg_sel == OFF_VECTOR);
   assign wr_ctrl    = wr && (reg_sel == OFF_CTRL);
   assign wr_mask    = wr && (reg_sel == OFF_MASK);
   assign wr_pending = wr && (reg_sel == OFF_PENDING);
   assign wr_eoi     = wr && (reg_sel == OFF_EOI);

   assign candidate = pending & mask;
   assign fall      = prev & ~irq_lines;

   irq_priority_encoder #(.n(num_lines)) u_prio (
      .req   (candidate),
      .id    (cand_id),
      .valid (cand_valid)
   );

   assign irq_on = ctrl[0] && cand_valid;
   assign ack    = (state == ST_ASSERT) && irq_on && rd_vector;

   always_comb begin
      ack_clr = '0;
      if (ack) ack_clr[cand_id] = 1'b1;
      w1c_clr = wr_pending ? data_bus_data[num_lines-1:0] : '0;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:       if (irq_on) state_next = ST_ASSERT;
         ST_ASSERT: begin
            if (!irq_on)        state_next = ST_IDLE;
            else if (rd_vector) state_next = ST_IN_SERVICE;
         end
         ST_IN_SERVICE: if (wr_eoi) state_next = ST_IDLE;
         default:       state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl          <= '0;
         mask          <= '0;
         pending       <= '0;
         prev          <= '1;
         in_service_id <= '0;
         state         <= ST_IDLE;
         cpu_irq       <= 1'b0;
         cpu_irq_id    <= '0;
      end else begin
         prev  <= irq_lines;
         state <= state_next;
         if (wr_ctrl) ctrl <= data_bus_data;
         if (wr_mask) mask <= data_bus_data[num_lines-1:0];
         // New edges are OR'd in after the clears so a same-cycle set wins.
         pending <= (pending & ~(w1c_clr | ack_clr)) | fall;
         if (ack) in_service_id <= cand_id;
         cpu_irq    <= (state_next == ST_ASSERT);
         cpu_irq_id <= (state_next == ST_ASSERT) ? cand_id : '0;
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_sel)
         OFF_CTRL:    rdata = ctrl;
         OFF_MASK:    rdata[num_lines-1:0] = mask;
         OFF_PENDING: rdata[num_lines-1:0] = pending;
         OFF_VECTOR: begin
            if (state == ST_ASSERT && irq_on) rdata = vector_word(1'b1, 1'b0, cand_id);
            else if (state == ST_IN_SERVICE)  rdata = vector_word(1'b0, 1'b1, in_service_id);
         end
         default:     rdata = '0;
      endcase
   end

   assign data_bus_data = rd ? rdata : 32'bz;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with hand-computed expectations.
module tb_irq_controller;
   import irq_pkg::*;

   localparam logic [31:0] BASE = 32'h40B0;
   localparam logic [31:0] PAT  = 32'h5AA5_C33C;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_lines = 8'hFF;
   logic [31:0] addr = '0;
   logic [1:0]  mode = 2'b00;
   logic [31:0] tb_wdata = '0;
   logic        tb_drive = 1'b0;
   wire  [31:0] data_bus_data;
   logic        cpu_irq;
   logic [2:0]  cpu_irq_id;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] d;

   assign data_bus_data = tb_drive ? tb_wdata : 32'bz;
   always #5 clk = ~clk;

   irq_controller #(.base_address(BASE), .num_lines(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .irq_lines     (irq_lines),
      .data_bus_data (data_bus_data),
      .data_bus_addr (addr),
      .data_bus_mode (mode),
      .cpu_irq       (cpu_irq),
      .cpu_irq_id    (cpu_irq_id)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] v);
      addr = BASE + 32'(off); mode = 2'b10; tb_wdata = v; tb_drive = 1'b1;
      tick();
      mode = 2'b00; tb_drive = 1'b0;
   endtask

   // Read that spans a clock edge, so side effects happen.
   task automatic rd(input logic [2:0] off, output logic [31:0] v);
      addr = BASE + 32'(off); mode = 2'b01;
      #1 v = data_bus_data;
      tick();
      mode = 2'b00;
   endtask

   // Read sampled and withdrawn between edges: no side effects.
   task automatic chk_reg(input string tag, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] v;
      addr = BASE + 32'(off); mode = 2'b01;
      #1 v = data_bus_data;
      mode = 2'b00;
      #1 chk(tag, v, exp);
   endtask

   task automatic chk_irq(input string tag, input logic exp_irq, input logic [2:0] exp_id);
      chk({tag, ".irq"}, 32'(cpu_irq), 32'(exp_irq));
      chk({tag, ".id"}, 32'(cpu_irq_id), 32'(exp_id));
   endtask

   // Bench drives a pattern on an unmapped read; any DUT drive would corrupt it.
   task automatic chk_free(input string tag, input logic [31:0] a);
      addr = a; mode = 2'b01; tb_wdata = PAT; tb_drive = 1'b1;
      #1 chk(tag, data_bus_data, PAT);
      mode = 2'b00; tb_drive = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      chk_irq("rst", 1'b0, 3'd0);
      chk_reg("rst.ctrl", OFF_CTRL, 32'h0);
      chk_reg("rst.mask", OFF_MASK, 32'h0);
      chk_reg("rst.pend", OFF_PENDING, 32'h0);
      chk_reg("rst.vec", OFF_VECTOR, 32'h0);
      chk_free("rst.free_hi", BASE + 32'd5);
      chk_free("rst.free_lo", BASE - 32'd1);

      // CTRL read-back, reserved mode ignored
      wr(OFF_CTRL, 32'hDEAD_BEE1);
      chk_reg("ctrl.rb", OFF_CTRL, 32'hDEAD_BEE1);
      addr = BASE; mode = 2'b11; tb_wdata = 32'h0; tb_drive = 1'b1;
      tick();
      mode = 2'b00; tb_drive = 1'b0;
      chk_reg("ctrl.mode11", OFF_CTRL, 32'hDEAD_BEE1);
      wr(OFF_CTRL, 32'h1);

      // Latency: edge at k -> pending after k, cpu_irq after k+1
      wr(OFF_MASK, 32'h01);
      irq_lines = 8'hFE;
      tick();
      chk_reg("lat.pend", OFF_PENDING, 32'h01);
      chk_irq("lat.k", 1'b0, 3'd0);
      tick();
      chk_irq("lat.k1", 1'b1, 3'd0);
      irq_lines = 8'hFF;
      rd(OFF_VECTOR, d);
      chk("lat.vec", d, 32'h8000_0000);
      chk_irq("lat.ack", 1'b0, 3'd0);
      chk_reg("lat.pend_clr", OFF_PENDING, 32'h0);
      wr(OFF_EOI, 32'h0);
      tick();
      chk_irq("lat.idle", 1'b0, 3'd0);

      // Simultaneous lines 5 and 2
      wr(OFF_MASK, 32'hFF);
      irq_lines = 8'hDB;
      tick();
      chk_reg("two.pend", OFF_PENDING, 32'h24);
      tick();
      chk_irq("two.assert", 1'b1, 3'd2);
      irq_lines = 8'hFF;
      rd(OFF_VECTOR, d);
      chk("two.vec", d, 32'h8000_0002);
      chk_reg("two.pend_ack", OFF_PENDING, 32'h20);
      chk_reg("two.vec_is", OFF_VECTOR, 32'h4000_0002);
      chk_irq("two.is", 1'b0, 3'd0);
      wr(OFF_EOI, 32'h0);
      tick();
      chk_irq("two.next", 1'b1, 3'd5);
      rd(OFF_VECTOR, d);
      chk("two.vec5", d, 32'h8000_0005);
      wr(OFF_EOI, 32'h0);

      // Preemption: line 4 asserted, line 1 arrives
      irq_lines = 8'hEF;
      tick(); tick();
      chk_irq("pre.4", 1'b1, 3'd4);
      irq_lines = 8'hED;
      tick();
      chk_irq("pre.hold", 1'b1, 3'd4);
      tick();
      chk_irq("pre.1", 1'b1, 3'd1);
      irq_lines = 8'hFF;
      rd(OFF_VECTOR, d);
      chk("pre.vec1", d, 32'h8000_0001);
      wr(OFF_EOI, 32'h0);
      tick();
      chk_irq("pre.back4", 1'b1, 3'd4);
      rd(OFF_VECTOR, d);
      wr(OFF_EOI, 32'h0);

      // No nesting while in service; VECTOR write has no effect
      irq_lines = 8'h7F;
      tick(); tick();
      chk_irq("nest.7", 1'b1, 3'd7);
      irq_lines = 8'hFF;
      rd(OFF_VECTOR, d);
      irq_lines = 8'hF7;
      tick(); tick();
      chk_irq("nest.quiet", 1'b0, 3'd0);
      chk_reg("nest.pend", OFF_PENDING, 32'h08);
      irq_lines = 8'hFF;
      wr(OFF_VECTOR, 32'hFFFF_FFFF);
      chk_reg("nest.vec_wr", OFF_VECTOR, 32'h4000_0007);
      wr(OFF_EOI, 32'h0);
      tick();
      chk_irq("nest.3", 1'b1, 3'd3);
      wr(OFF_EOI, 32'h0);
      chk_irq("eoi.ignored", 1'b1, 3'd3);
      rd(OFF_VECTOR, d);
      chk("nest.vec3", d, 32'h8000_0003);
      wr(OFF_EOI, 32'h0);

      // W1C vs same-cycle edge
      wr(OFF_MASK, 32'h00);
      irq_lines = 8'hFC;
      tick();
      irq_lines = 8'hFF;
      chk_reg("w1c.pre", OFF_PENDING, 32'h03);
      irq_lines = 8'hBF;
      wr(OFF_PENDING, 32'hFF);
      irq_lines = 8'hFF;
      chk_reg("w1c.setwins", OFF_PENDING, 32'h40);
      wr(OFF_PENDING, 32'h40);
      chk_reg("w1c.clr", OFF_PENDING, 32'h0);

      // Reset while in service
      wr(OFF_MASK, 32'hFF);
      irq_lines = 8'hFB;
      tick(); tick();
      irq_lines = 8'hBF;
      rd(OFF_VECTOR, d);
      chk("rst2.vec", d, 32'h8000_0002);
      reset = 1'b1;
      irq_lines = 8'hDF;
      tick();
      tick();
      chk_irq("rst2", 1'b0, 3'd0);
      chk_reg("rst2.ctrl", OFF_CTRL, 32'h0);
      chk_reg("rst2.mask", OFF_MASK, 32'h0);
      chk_reg("rst2.pend", OFF_PENDING, 32'h0);
      chk_reg("rst2.vec", OFF_VECTOR, 32'h0);
      chk_free("rst2.free", BASE + 32'h100);

      // Line 5 held low across reset release: exactly one edge
      reset = 1'b0;
      tick(); tick(); tick();
      chk_reg("hold.pend", OFF_PENDING, 32'h20);
      wr(OFF_PENDING, 32'h20);
      tick();
      chk_reg("hold.once", OFF_PENDING, 32'h0);
      irq_lines = 8'hFF;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
